full_shifter: RTL and testbench
===============================

Name: full_shifter

Overview:
- 32-bit barrel shifter used by the ALU for shift operations.
- Performs a logical left shift or an arithmetic right shift by 0–31 bit positions.
- The shifter core is combinational (log-depth, 5 stages of 1/2/4/8/16); its output is captured in a 32-bit output register.
- Sits on the ALU shift path; the ALU result mux consumes the registered result.

Parameters:
- none (width fixed at 32, shift amount fixed at 5 bits)

Ports:
- clk     input   1   sole clock, rising-edge active
- reset   input   1   asynchronous, active-high; clears output register
- A       input   32  operand to shift
- d       input   1   direction: 0 = shift left logical, 1 = shift right arithmetic
- amt     input   5   shift amount, unsigned, 0–31
- result  output  32  registered shift result

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high.
- Reset:
  - While reset = 1, result = 32'h0000_0000 immediately, independent of clk.
  - On reset deassertion, result stays 0 until the next rising clk edge.
- Core function, combinational from A/d/amt:
  - d = 0: core = A << amt; vacated LSBs filled with 0; bits shifted past bit 31 are discarded.
  - d = 1: core = A >>> amt; vacated MSBs filled with A[31] (sign extension); bits shifted below bit 0 are discarded.
- Structure: five cascaded stages. Stage k shifts by 2^k when amt[k] = 1, otherwise passes through. Stage order is 1, 2, 4, 8, 16. Any order is acceptable if the result is identical.
- Register:
  - On every rising clk edge with reset = 0, result <= core(A, d, amt).
  - Latency is exactly 1 cycle; a new input can be applied every cycle.
  - There is no enable and no handshake.
- Boundary conditions:
  - amt = 0: result = A for both directions.
  - amt = 31, d = 1: result = 32'hFFFF_FFFF if A[31] = 1, else 32'h0000_0000.
  - amt = 31, d = 0: result = {A[0], 31'b0}.
  - Inputs changing between edges have no effect on result until the next edge.
  - Reset asserted mid-stream overrides any pending capture; the first valid result after deassertion reflects inputs sampled at the first rising edge with reset = 0.
  - X/Z on inputs is not handled specially.

Test Plan:
1. Reset → result: assert reset with A = 32'h9666_B7A8 → result = 0 with no clock edge. Deassert and clock once with d = 0, amt = 0 → result = 32'h9666_B7A8.
2. Arithmetic right, negative operand: A = 32'h9666_B7A8, d = 1, amt = 5'b00111 → one cycle later result = 32'hFF2C_CD6F.
3. Left logical: A = 32'h9666_B7A8, d = 0, amt = 7 → result = 32'h335B_D400.
4. Extremes at amt = 31:
   - A = 32'h8000_0000, d = 1 → 32'hFFFF_FFFF
   - A = 32'h7FFF_FFFF, d = 1 → 32'h0000_0000
   - A = 32'h0000_0001, d = 0 → 32'h8000_0000
5. Stage isolation: A = 32'h0000_0001, d = 0, amt = 1, 2, 4, 8, 16 in consecutive cycles → result = 32'h2, 32'h4, 32'h10, 32'h100, 32'h1_0000, each one cycle after its input (back-to-back throughput).
6. Async reset mid-stream: apply reset between edges while result = 32'hFF2C_CD6F → result goes to 0 immediately. Hold reset across two clk edges → result stays 0.

Source files
------------

// File: rtl/full_shifter.sv
// full_shifter: 32-bit log-depth barrel shifter (SLL / SRA) with a registered result.
module full_shifter (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic        d,
  input  logic [4:0]  amt,
  output logic [31:0] result
);
  logic [5:0][31:0] s;
  assign s[0] = A;
  for (genvar k = 0; k < 5; k++) begin : g_stage
    localparam int N = 1 << k;
    // s[k][31] equals A[31] at every stage, so right-shift fill stays the sign bit
    assign s[k+1] = !amt[k] ? s[k] :
                    d       ? {{N{s[k][31]}}, s[k][31:N]} :
                              {s[k][31-N:0], {N{1'b0}}};
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) result <= '0;
    else       result <= s[5];
endmodule

// File: tb/tb_full_shifter.sv
// tb_full_shifter: directed table, corner sequences and randomized model checks for full_shifter.
module tb_full_shifter;
  logic        clk, reset, d;
  logic [31:0] A, result;
  logic [4:0]  amt;
  int vectors = 0, miscompares = 0;

  full_shifter dut (.clk(clk), .reset(reset), .A(A), .d(d), .amt(amt), .result(result));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] a;
    logic        dir;
    logic [4:0]  n;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[12];

  function automatic logic [31:0] ref_shift(logic [31:0] a, logic dir, logic [4:0] n);
    logic [63:0] p;
    p = 64'(a) * (64'd1 << n);
    if (!dir) return p[31:0];
    return a[31] ? ~((~a) >> n) : (a >> n);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(logic [31:0] a, logic dir, logic [4:0] n);
    A = a; d = dir; amt = n;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = '{32'h9666_B7A8, 1'b1, 5'd7,  32'hFF2C_CD6F};
    tbl[1]  = '{32'h9666_B7A8, 1'b0, 5'd7,  32'h335B_D400};
    tbl[2]  = '{32'h8000_0000, 1'b1, 5'd31, 32'hFFFF_FFFF};
    tbl[3]  = '{32'h7FFF_FFFF, 1'b1, 5'd31, 32'h0000_0000};
    tbl[4]  = '{32'h0000_0001, 1'b0, 5'd31, 32'h8000_0000};
    tbl[5]  = '{32'h9666_B7A8, 1'b1, 5'd0,  32'h9666_B7A8};
    tbl[6]  = '{32'h0000_0001, 1'b0, 5'd1,  32'h0000_0002};
    tbl[7]  = '{32'h0000_0001, 1'b0, 5'd2,  32'h0000_0004};
    tbl[8]  = '{32'h0000_0001, 1'b0, 5'd4,  32'h0000_0010};
    tbl[9]  = '{32'h0000_0001, 1'b0, 5'd8,  32'h0000_0100};
    tbl[10] = '{32'h0000_0001, 1'b0, 5'd16, 32'h0001_0000};
    tbl[11] = '{32'h4000_0000, 1'b1, 5'd30, 32'h0000_0001};

    reset = 0; A = 32'h9666_B7A8; d = 0; amt = 0;
    #2 reset = 1;
    #1 check("reset_async", result, 32'h0);
    @(posedge clk); #1;
    check("reset_hold", result, 32'h0);
    #2 reset = 0;
    #1 check("reset_release_no_edge", result, 32'h0);
    apply(32'h9666_B7A8, 1'b0, 5'd0);
    check("first_after_reset", result, 32'h9666_B7A8);

    for (int i = 0; i < 12; i++) begin
      apply(tbl[i].a, tbl[i].dir, tbl[i].n);
      check($sformatf("table[%0d]", i), result, tbl[i].exp);
    end

    apply(32'h9666_B7A8, 1'b1, 5'd7);
    A = 32'h1234_5678; d = 0; amt = 5'd3;
    #3 check("inputs_between_edges", result, 32'hFF2C_CD6F);
    #1 reset = 1;
    #1 check("reset_midstream", result, 32'h0);
    repeat (2) begin
      @(posedge clk); #1;
      check("reset_held_over_edge", result, 32'h0);
    end
    #2 reset = 0;
    apply(32'hC000_0005, 1'b1, 5'd1);
    check("first_after_midreset", result, 32'hE000_0002);

    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      logic dir;
      logic [4:0] n;
      a = $urandom;
      dir = 1'($urandom_range(0, 1));
      n = 5'($urandom_range(0, 31));
      apply(a, dir, n);
      check($sformatf("random a=%h d=%0d amt=%0d", a, dir, n), result, ref_shift(a, dir, n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
